// File: rtl/key_tx_pkg.sv
// Shared constants, types and the keypad-code to ASCII map for the keypad UART encoder.
package key_tx_pkg;

  localparam logic [7:0] ASC_0      = 8'h30;
  localparam logic [7:0] ASC_A      = 8'h41;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_UNLOCK = 8'h37;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DRAIN
  } tx_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } key_byte_t;

  // The unlock code wins over the digit range so any code can be chosen for the door key.
  function automatic key_byte_t key_to_ascii(input logic [3:0] num,
                                             input logic [3:0] unlock_code);
    key_byte_t r;
    r       = '0;
    r.valid = 1'b1;
    if (num == unlock_code)  r.data = ASC_UNLOCK;
    else if (num <= 4'd9)    r.data = ASC_0 + {4'h0, num};
    else if (num == 4'd14)   r.data = ASC_A;
    else                     r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: storage is deliberately not reset; count and pointers say which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/key_tx_encoder.sv
// Keypad press to ASCII encoder: queues bytes for the UART TX handshake and times the door unlock.
module key_tx_encoder
  import key_tx_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int START_PULSE_CYC = 4,
  parameter int APPEND_CR       = 1,
  parameter int UNLOCK_CODE     = 13,
  parameter int UNLOCK_HOLD_CYC = 50_000_000
) (
  input  logic                          FPGA_CLK1_50,
  input  logic                          reset,
  input  logic [3:0]                    num,
  input  logic                          PB_state,
  input  logic                          TxD_busy,
  output logic [7:0]                    TxD_data,
  output logic                          TxD_start,
  output logic                          unlock_signal,
  output logic [7:0]                    LED,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW   = $clog2(START_PULSE_CYC + 1);
  localparam int UW   = $clog2(UNLOCK_HOLD_CYC + 1);
  localparam int NEED = (APPEND_CR != 0) ? 2 : 1;

  logic            pb_prev;
  logic            press;
  key_byte_t       key_map;
  logic            wr_key_q;
  logic            cr_q;
  logic [7:0]      key_q;
  int              occupied;
  logic            space_ok;
  logic            push;
  logic [7:0]      push_data;
  logic            load;
  logic [7:0]      head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [PW-1:0]   pulse_cnt;
  logic [UW-1:0]   unlock_cnt;
  tx_state_t       state;
  tx_state_t       state_nx;

  assign press   = PB_state & ~pb_prev;
  assign key_map = key_to_ascii(num, 4'(UNLOCK_CODE));

  // Bytes already promised to the queue but not yet written count as occupied.
  always_comb begin
    occupied = int'(fifo_count) + (wr_key_q ? NEED : 0) + (cr_q ? 1 : 0);
    space_ok = !fifo_full && ((occupied + NEED) <= FIFO_DEPTH);
  end

  // History resets high so a key held through reset release is not a press.
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      pb_prev  <= 1'b1;
      wr_key_q <= 1'b0;
      cr_q     <= 1'b0;
      key_q    <= '0;
      overflow <= 1'b0;
    end else begin
      pb_prev  <= PB_state;
      wr_key_q <= 1'b0;
      cr_q     <= wr_key_q && (APPEND_CR != 0);
      if (press && key_map.valid) begin
        if (space_ok) begin
          wr_key_q <= 1'b1;
          key_q    <= key_map.data;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign push      = wr_key_q | cr_q;
  assign push_data = wr_key_q ? key_q : ASC_CR;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (FPGA_CLK1_50),
    .rst     (reset),
    .push    (push),
    .wr_data (push_data),
    .pop     (load),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    TxD_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !TxD_busy) begin
          load     = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        TxD_start = 1'b1;
        if (pulse_cnt == PW'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!TxD_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      pulse_cnt <= '0;
      TxD_data  <= '0;
      LED       <= '0;
    end else begin
      if (load) begin
        pulse_cnt <= PW'(START_PULSE_CYC);
        TxD_data  <= head;
        LED       <= head;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end
  end

  // A repeat press reloads the hold time; the count stops at zero.
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      unlock_cnt <= '0;
    end else if (press && (num == 4'(UNLOCK_CODE))) begin
      unlock_cnt <= UW'(UNLOCK_HOLD_CYC);
    end else if (unlock_cnt != '0) begin
      unlock_cnt <= unlock_cnt - 1'b1;
    end
  end

  assign unlock_signal = (unlock_cnt != '0);

endmodule

// File: tb/tb_key_tx_encoder.sv
// Self-checking bench for key_tx_encoder: queue-based byte model, unlock timer model, UART busy model.
module tb_key_tx_encoder;

  localparam int DEPTH    = 8;
  localparam int PULSE    = 4;
  localparam int HOLD     = 10;
  localparam int UCODE    = 13;
  localparam int BUSY_LEN = 20;

  logic       FPGA_CLK1_50 = 1'b0;
  logic       reset        = 1'b1;
  logic [3:0] num          = '0;
  logic       PB_state     = 1'b0;
  logic       TxD_busy     = 1'b0;
  logic [7:0] TxD_data;
  logic       TxD_start;
  logic       unlock_signal;
  logic [7:0] LED;
  logic [3:0] fifo_count;
  logic       overflow;

  key_tx_encoder #(
    .FIFO_DEPTH      (DEPTH),
    .START_PULSE_CYC (PULSE),
    .APPEND_CR       (1),
    .UNLOCK_CODE     (UCODE),
    .UNLOCK_HOLD_CYC (HOLD)
  ) dut (
    .FPGA_CLK1_50  (FPGA_CLK1_50),
    .reset         (reset),
    .num           (num),
    .PB_state      (PB_state),
    .TxD_busy      (TxD_busy),
    .TxD_data      (TxD_data),
    .TxD_start     (TxD_start),
    .unlock_signal (unlock_signal),
    .LED           (LED),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: bytes owed to the UART, sticky overflow, unlock time left.
  logic [7:0] exp_q[$];
  bit         model_ovf = 1'b0;
  int         unlock_rem = 0;
  bit         pb_prev_m = 1'b1;
  int         m_a;
  bit         m_press;

  function automatic int model_ascii(input int k);
    if (k == UCODE) return 'h37;
    if (k <= 9)     return 'h30 + k;
    if (k == 14)    return 'h41;
    return -1;
  endfunction

  always @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      exp_q.delete();
      model_ovf  = 1'b0;
      unlock_rem = 0;
      pb_prev_m  = 1'b1;
    end else begin
      m_press = PB_state && !pb_prev_m;
      if (m_press) begin
        m_a = model_ascii(int'(num));
        if (m_a >= 0) begin
          if (exp_q.size() + 2 > DEPTH) model_ovf = 1'b1;
          else begin
            exp_q.push_back(8'(m_a));
            exp_q.push_back(8'h0D);
          end
        end
      end
      if (m_press && int'(num) == UCODE) unlock_rem = HOLD;
      else if (unlock_rem > 0)           unlock_rem--;
      pb_prev_m = PB_state;
    end
  end

  // UART model: busy for BUSY_LEN cycles from the first start cycle, or forced.
  bit force_busy = 1'b0;
  int busy_cnt = 0;
  bit u_prev = 1'b0;

  always @(negedge FPGA_CLK1_50) begin
    if (reset) begin
      busy_cnt = 0;
      u_prev   = 1'b0;
    end else begin
      if (TxD_start && !u_prev) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0)    busy_cnt--;
      u_prev = TxD_start;
    end
    TxD_busy = force_busy || (busy_cnt > 0);
  end

  // Compare process: byte order, pulse width, unlock level, overflow flag.
  bit         mon_prev = 1'b0;
  int         mon_hi = 0;
  logic [7:0] m_e;

  always @(negedge FPGA_CLK1_50) begin
    if (reset) begin
      mon_prev = 1'b0;
      mon_hi   = 0;
    end else begin
      if (TxD_start && !mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got TxD_data 0x%0h, expected no transmission", TxD_data);
        end else begin
          m_e = exp_q.pop_front();
          check("tx_data", TxD_data, m_e);
          check("led", LED, m_e);
        end
      end
      if (TxD_start) mon_hi++;
      else if (mon_prev) begin
        check("start_width", mon_hi, PULSE);
        mon_hi = 0;
      end
      check("unlock", unlock_signal, unlock_rem > 0);
      check("overflow", overflow, model_ovf);
      mon_prev = TxD_start;
    end
  end

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    @(negedge FPGA_CLK1_50);
    num      = k;
    PB_state = 1'b1;
    repeat (hold) @(negedge FPGA_CLK1_50);
    PB_state = 1'b0;
    repeat (gap) @(negedge FPGA_CLK1_50);
  endtask

  task automatic get_byte(input string name, output logic [7:0] b);
    int n = 0;
    while (TxD_start && n < 100) begin @(negedge FPGA_CLK1_50); n++; end
    while (!TxD_start && n < 200) begin @(negedge FPGA_CLK1_50); n++; end
    if (!TxD_start) begin
      checks++;
      errors++;
      $display("FAIL %s: got no TxD_start within %0d cycles, expected one", name, n);
      b = 8'hEE;
    end else begin
      b = TxD_data;
    end
  endtask

  task automatic count_starts(input int cyc, output int n);
    bit p = TxD_start;
    n = 0;
    repeat (cyc) begin
      @(negedge FPGA_CLK1_50);
      if (TxD_start && !p) n++;
      p = TxD_start;
    end
  endtask

  task automatic wait_idle(input string name);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 400) begin
      @(negedge FPGA_CLK1_50);
      n++;
      if (!TxD_start && !TxD_busy && fifo_count == 0) stable++;
      else stable = 0;
    end
    if (stable < 4) begin
      checks++;
      errors++;
      $display("FAIL %s: got fifo_count=%0d busy=%0b after %0d cycles, expected idle", name, fifo_count, TxD_busy, n);
    end
  endtask

  logic [7:0] t2_exp [6] = '{8'h31, 8'h0D, 8'h32, 8'h0D, 8'h41, 8'h0D};
  logic [7:0] t3_exp [8] = '{8'h31, 8'h0D, 8'h32, 8'h0D, 8'h33, 8'h0D, 8'h34, 8'h0D};

  initial begin
    int         w;
    int         n;
    int         hi;
    bit         got;
    bit         prevs;
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] cap [2];

    // Reset state, sampled while reset is held.
    repeat (3) @(posedge FPGA_CLK1_50);
    #1;
    check("rst_start", TxD_start, 0);
    check("rst_data", TxD_data, 0);
    check("rst_led", LED, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unlock", unlock_signal, 0);
    @(negedge FPGA_CLK1_50);
    reset = 1'b0;
    repeat (2) @(negedge FPGA_CLK1_50);

    // Single key 5: latency, width, data, then CR.
    num = 4'd5;
    PB_state = 1'b1;
    @(posedge FPGA_CLK1_50);
    @(negedge FPGA_CLK1_50);
    PB_state = 1'b0;
    @(posedge FPGA_CLK1_50); #1;
    check("t1_start_edge1", TxD_start, 0);
    @(posedge FPGA_CLK1_50); #1;
    check("t1_start_edge2", TxD_start, 1);
    check("t1_data", TxD_data, 8'h35);
    w = 0;
    while (TxD_start && w < 20) begin @(posedge FPGA_CLK1_50); #1; w++; end
    check("t1_width", w, PULSE);
    get_byte("t1_cr_start", b);
    check("t1_cr", b, 8'h0D);
    check("t1_led", LED, 8'h0D);
    wait_idle("t1_idle");
    check("t1_count", fifo_count, 0);

    // Three presses while busy: queue depth and order.
    force_busy = 1'b1;
    repeat (2) @(negedge FPGA_CLK1_50);
    press(4'd1, 2, 2);
    press(4'd2, 2, 2);
    press(4'd14, 2, 2);
    repeat (3) @(negedge FPGA_CLK1_50);
    check("t2_count", fifo_count, 6);
    force_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      get_byte("t2_start", b);
      check("t2_order", b, t2_exp[i]);
    end
    wait_idle("t2_idle");

    // Fill the queue, then overflow on a fifth key.
    force_busy = 1'b1;
    repeat (2) @(negedge FPGA_CLK1_50);
    press(4'd1, 1, 2);
    press(4'd2, 1, 2);
    press(4'd3, 1, 2);
    press(4'd4, 1, 2);
    check("t3_full_count", fifo_count, 8);
    check("t3_no_ovf_yet", overflow, 0);
    press(4'd9, 1, 2);
    check("t3_ovf", overflow, 1);
    check("t3_count_kept", fifo_count, 8);
    force_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      get_byte("t3_start", b);
      check("t3_order", b, t3_exp[i]);
    end
    count_starts(80, n);
    check("t3_no_39", n, 0);
    wait_idle("t3_idle");

    // Unlock: single press holds for HOLD cycles.
    @(negedge FPGA_CLK1_50);
    num = 4'd13;
    PB_state = 1'b1;
    @(posedge FPGA_CLK1_50);
    hi = 0; got = 1'b0; d = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge FPGA_CLK1_50);
      if (c == 1) PB_state = 1'b0;
      if (unlock_signal) hi++;
      if (c == 10) check("t4_last_high", unlock_signal, 1);
      if (c == 11) check("t4_first_low", unlock_signal, 0);
      if (TxD_start && !got) begin got = 1'b1; d = TxD_data; end
    end
    check("t4_hold", hi, HOLD);
    check("t4_data", d, 8'h37);
    wait_idle("t4_idle");

    // Unlock: a second press five cycles later restarts the hold.
    @(negedge FPGA_CLK1_50);
    num = 4'd13;
    PB_state = 1'b1;
    @(posedge FPGA_CLK1_50);
    hi = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge FPGA_CLK1_50);
      if (c == 1) PB_state = 1'b0;
      if (c == 5) PB_state = 1'b1;
      if (c == 6) PB_state = 1'b0;
      if (unlock_signal) hi++;
      if (c == 15) check("t4b_last_high", unlock_signal, 1);
      if (c == 16) check("t4b_first_low", unlock_signal, 0);
    end
    check("t4b_hold", hi, HOLD + 5);
    wait_idle("t4b_idle");

    // Ignored code 11, then key 3 held for 100 cycles with num wandering.
    press(4'd11, 2, 2);
    count_starts(40, n);
    check("t5_no_byte_11", n, 0);
    check("t5_count_11", fifo_count, 0);
    @(negedge FPGA_CLK1_50);
    num = 4'd3;
    PB_state = 1'b1;
    n = 0;
    prevs = TxD_start;
    cap[0] = 8'h00;
    cap[1] = 8'h00;
    for (int c = 0; c < 160; c++) begin
      @(negedge FPGA_CLK1_50);
      if (c < 100) num = 4'($urandom_range(0, 15));
      if (c == 99) PB_state = 1'b0;
      if (TxD_start && !prevs) begin
        if (n < 2) cap[n] = TxD_data;
        n++;
      end
      prevs = TxD_start;
    end
    check("t5_held_bytes", n, 2);
    check("t5_held_key", cap[0], 8'h33);
    check("t5_held_cr", cap[1], 8'h0D);
    wait_idle("t5_idle");

    // Reset during the start pulse with four bytes queued; key held through release.
    @(negedge FPGA_CLK1_50);
    num = 4'd1;
    PB_state = 1'b1;
    @(posedge FPGA_CLK1_50);
    @(negedge FPGA_CLK1_50);
    PB_state = 1'b0;
    @(negedge FPGA_CLK1_50);
    num = 4'd2;
    PB_state = 1'b1;
    @(posedge FPGA_CLK1_50);
    @(negedge FPGA_CLK1_50);
    PB_state = 1'b0;
    @(negedge FPGA_CLK1_50);
    num = 4'd3;
    PB_state = 1'b1;
    @(posedge FPGA_CLK1_50);
    @(negedge FPGA_CLK1_50);
    PB_state = 1'b0;
    @(posedge FPGA_CLK1_50); #2;
    check("t6_in_pulse", TxD_start, 1);
    check("t6_queued", fifo_count, 4);
    reset = 1'b1;
    num = 4'd5;
    PB_state = 1'b1;
    #1;
    check("t6_start_drop", TxD_start, 0);
    check("t6_count_clr", fifo_count, 0);
    check("t6_data_clr", TxD_data, 0);
    repeat (3) @(posedge FPGA_CLK1_50);
    @(negedge FPGA_CLK1_50);
    reset = 1'b0;
    count_starts(25, n);
    check("t6_no_start", n, 0);
    check("t6_count_after", fifo_count, 0);
    check("t6_ovf_after", overflow, 0);
    PB_state = 1'b0;
    repeat (3) @(negedge FPGA_CLK1_50);

    // Random presses, holds, gaps and busy stretches against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) force_busy = !force_busy;
      press(4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(1, 30));
    end
    force_busy = 1'b0;
    wait_idle("rand_idle");
    check("rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation exceeded its time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_tx_encoder.md
Name: key_tx_encoder

Overview:
Parametrised successor to the keypad-to-UART encoder.
- Converts each keypad press (4-bit key code plus pressed flag) into ASCII bytes.
- Queues the bytes in a FIFO and sends them one at a time to the UART transmitter over a start/busy handshake. Presses arriving during a transmission are therefore never lost.
- Drives a timed unlock output for the door-release key.
- Sits between the keypad scanner and the UART TX block.

Parameters:
- FIFO_DEPTH, 8: byte queue depth; power of two, >= 2.
- START_PULSE_CYC, 4: cycles TxD_start is held high; >= 2.
- APPEND_CR, 1: 1 = every accepted key is followed by 0x0D; 0 = key byte only.
- UNLOCK_CODE, 13: key code that asserts unlock_signal.
- UNLOCK_HOLD_CYC, 50_000_000: unlock_signal high time in clocks (1 s at 50 MHz).

Ports:
- FPGA_CLK1_50, in, 1: system clock, 50 MHz.
- reset, in, 1: asynchronous, active-high reset.
- num, in, 4: key code from the scanner; valid while PB_state = 1.
- PB_state, in, 1: key pressed level.
- TxD_busy, in, 1: UART transmitter busy.
- TxD_data, out, 8: byte to transmit; stable from load until the next load.
- TxD_start, out, 1: transmit request pulse.
- unlock_signal, out, 1: door unlock, timed.
- LED, out, 8: last byte loaded into TxD_data.
- fifo_count, out, $clog2(FIFO_DEPTH)+1: bytes queued.
- overflow, out, 1: sticky; a key was dropped for lack of space.

Behaviour:
- Reset (async, active-high):
  - FIFO emptied.
  - TxD_data, LED, fifo_count and overflow = 0.
  - TxD_start and unlock_signal = 0 immediately.
  - FSM returns to IDLE.
  - PB_state history register resets to 1, so a key held through reset release is not counted.
- Press detection: a press is the first clock edge where PB_state = 1 and its registered previous value = 0. num is sampled on that edge. Exactly one press per PB_state high period.
- Key map:
  - 0-9 -> 0x30-0x39.
  - 14 -> 0x41.
  - UNLOCK_CODE -> 0x37, plus unlock.
  - All other codes (including 11 = no key) are ignored: no enqueue, no unlock.
- Enqueue on the press edge:
  - Needs 1 free slot, or 2 when APPEND_CR = 1.
  - With APPEND_CR = 1, the key byte is written first and 0x0D second, on consecutive cycles. A dequeue on the same cycles is permitted.
  - If there is insufficient space, nothing is written (no partial pair) and overflow is set. overflow clears only on reset.
- FIFO: simultaneous push and pop allowed; fifo_count is unchanged in that case. A pop on empty never occurs by construction.
- TX FSM, one transition per clock:
  - IDLE: if fifo_count > 0 and TxD_busy = 0, load TxD_data and LED with the head byte, pop, go to START.
  - START: TxD_start = 1 for exactly START_PULSE_CYC cycles, then go to DRAIN.
  - DRAIN: TxD_start = 0; wait for TxD_busy = 0, then go to IDLE.
  - The UART asserts TxD_busy within the START pulse.
- Latency: with the FIFO empty and TxD_busy = 0, TxD_start rises 2 clock edges after the press edge.
  - Consecutive bytes are separated by at least START_PULSE_CYC + 1 cycles.
  - No gap beyond the busy time plus 1 idle cycle.
- Unlock:
  - On a press of UNLOCK_CODE, unlock_signal goes high from the next cycle for UNLOCK_HOLD_CYC cycles.
  - A repeat press restarts the count.
  - Unlock is asserted even if the bytes were dropped for overflow.
- Reset mid-transmission: the byte is abandoned and the queue is lost. No TxD_start glitch after reset release.
- Counter widths: the pulse counter is $clog2(START_PULSE_CYC+1) bits; the unlock counter is $clog2(UNLOCK_HOLD_CYC+1) bits. Neither wraps; both saturate at zero.

Decomposition:
- Package key_tx_pkg contains:
  - ASCII constants (ASC_0 = 0x30, ASC_A = 0x41, ASC_CR = 0x0D, ASC_UNLOCK = 0x37).
  - tx_state_t enum {IDLE, START, DRAIN}.
  - Function key_to_ascii(num) returning {valid, byte}.
- One sub-module: sync_fifo, parametrised by width and depth, with push/pop/count/full/empty outputs. key_tx_encoder instantiates it with width 8.

Test Plan:
- Reset, then press key 5 (APPEND_CR = 1, UART model: busy for 20 cycles from the first start cycle) -> TxD_start 2 edges after the press, 4 cycles wide, TxD_data = 0x35. Then 0x0D after busy falls; LED = 0x0D; fifo_count returns to 0.
- Three presses (1, 2, 14) while TxD_busy is held high -> fifo_count = 6. On release of busy, transmit order is 0x31, 0x0D, 0x32, 0x0D, 0x41, 0x0D, one TxD_start per byte.
- Fill FIFO_DEPTH = 8 with 4 presses, busy held, then a 5th press of 9 -> overflow = 1, fifo_count stays 8, and 0x39 is never transmitted.
- Press 13 with UNLOCK_HOLD_CYC = 10 -> unlock_signal high exactly 10 cycles starting the cycle after the press, and 0x37 transmitted. A second press at cycle 5 extends the high time to cycle 15.
- Press 11, and also hold PB_state high for 100 cycles on key 3 -> no byte for 11; exactly one 0x33 plus 0x0D for the held key.
- Assert reset during the START pulse with 4 bytes queued -> TxD_start drops the same cycle, fifo_count = 0, and no TxD_start for 20 cycles after release.
